// File: rtl/bary_attr_interp_if.sv
// Sample stream between the divider, the barycentric interpolator and the shading stage:
// lambda1/lambda2 in, clamped attribute out, each side with its own valid/ready handshake.
interface bary_attr_interp_if #(
  parameter int unsigned ATTR_W = 16,
  parameter int unsigned Q_W    = 14
);
  logic              in_valid;
  logic              in_ready;
  logic [Q_W-1:0]    lambda1;
  logic [Q_W-1:0]    lambda2;
  logic              out_valid;
  logic              out_ready;
  logic [ATTR_W-1:0] attr_out;

  modport master (
    output in_valid, lambda1, lambda2, out_ready,
    input  in_ready, out_valid, attr_out
  );

  modport slave (
    input  in_valid, lambda1, lambda2, out_ready,
    output in_ready, out_valid, attr_out
  );
endinterface

// File: rtl/bary_attr_interp.sv
// Barycentric attribute interpolator: A = a0*l0 + a1*l1 + a2*l2, with l0 = 1 - l1 - l2.
// The 3-stage stallable pipeline rounds half up and clamps the result to the attribute range.
module bary_attr_interp #(
  parameter int unsigned ATTR_W = 16,
  parameter int unsigned Q_W    = 14,
  parameter int unsigned FRAC   = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                attr_load,
  input  logic [ATTR_W-1:0]   attr0,
  input  logic [ATTR_W-1:0]   attr1,
  input  logic [ATTR_W-1:0]   attr2,
  bary_attr_interp_if.slave   bus,
  output logic                busy
);

  localparam int unsigned LW = Q_W + 2;
  localparam int unsigned PW = ATTR_W + 1 + LW;
  localparam int unsigned SW = 36;

  localparam logic signed [LW-1:0] ONE  = LW'(2 ** FRAC);
  localparam logic signed [SW-1:0] HALF = SW'(2 ** (FRAC - 1));
  localparam logic signed [SW-1:0] MAXV = SW'((2 ** ATTR_W) - 1);

  logic [ATTR_W-1:0]        r_a0, r_a1, r_a2;
  logic                     r_v1, r_v2, r_v3;
  logic signed [LW-1:0]     r_l0, r_l1, r_l2;
  logic [ATTR_W-1:0]        r_s1_a0, r_s1_a1, r_s1_a2;
  logic signed [PW-1:0]     r_p0, r_p1, r_p2;
  logic [ATTR_W-1:0]        r_attr_out;

  logic                     w_en1, w_en2, w_en3;
  logic                     w_in_ready, w_accept;
  logic signed [LW-1:0]     w_l1_ext, w_l2_ext, w_l0;
  logic signed [SW-1:0]     w_sum, w_rnd;
  logic [ATTR_W-1:0]        w_clamp;

  // Unsigned attribute widened to signed, then multiplied by a signed weight.
  function automatic logic signed [PW-1:0] mul_attr(
    input logic [ATTR_W-1:0]    a,
    input logic signed [LW-1:0] l
  );
    mul_attr = PW'($signed({1'b0, a})) * PW'(l);
  endfunction

  // A stage may load when it is empty or its content is moving on this cycle.
  assign w_en3      = !r_v3 || bus.out_ready;
  assign w_en2      = !r_v2 || w_en3;
  assign w_en1      = !r_v1 || w_en2;
  assign w_in_ready = !rst && w_en1;
  assign w_accept   = bus.in_valid && w_in_ready;

  assign w_l1_ext = LW'($signed(bus.lambda1));
  assign w_l2_ext = LW'($signed(bus.lambda2));
  assign w_l0     = ONE - w_l1_ext - w_l2_ext;

  assign w_sum = SW'(r_p0) + SW'(r_p1) + SW'(r_p2) + HALF;
  assign w_rnd = w_sum >>> FRAC;

  always_comb begin
    w_clamp = w_rnd[ATTR_W-1:0];
    if (w_rnd < 0) begin
      w_clamp = '0;
    end else if (w_rnd > MAXV) begin
      w_clamp = '1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a0       <= '0;
      r_a1       <= '0;
      r_a2       <= '0;
      r_v1       <= 1'b0;
      r_v2       <= 1'b0;
      r_v3       <= 1'b0;
      r_l0       <= '0;
      r_l1       <= '0;
      r_l2       <= '0;
      r_s1_a0    <= '0;
      r_s1_a1    <= '0;
      r_s1_a2    <= '0;
      r_p0       <= '0;
      r_p1       <= '0;
      r_p2       <= '0;
      r_attr_out <= '0;
    end else begin
      if (attr_load) begin
        r_a0 <= attr0;
        r_a1 <= attr1;
        r_a2 <= attr2;
      end
      // Each sample carries its own attribute snapshot through the pipe.
      if (w_en1) begin
        r_v1 <= w_accept;
        if (w_accept) begin
          r_l0    <= w_l0;
          r_l1    <= w_l1_ext;
          r_l2    <= w_l2_ext;
          r_s1_a0 <= r_a0;
          r_s1_a1 <= r_a1;
          r_s1_a2 <= r_a2;
        end
      end
      if (w_en2) begin
        r_v2 <= r_v1;
        if (r_v1) begin
          r_p0 <= mul_attr(r_s1_a0, r_l0);
          r_p1 <= mul_attr(r_s1_a1, r_l1);
          r_p2 <= mul_attr(r_s1_a2, r_l2);
        end
      end
      if (w_en3) begin
        r_v3 <= r_v2;
        if (r_v2) begin
          r_attr_out <= w_clamp;
        end
      end
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_v3;
  assign bus.attr_out  = r_attr_out;
  assign busy          = r_v1 | r_v2 | r_v3;

endmodule

// File: tb/tb_bary_attr_interp.sv
// Directed bench for bary_attr_interp: exact weights, rounding, clamping, stall/ordering,
// attribute snapshot timing and mid-stream reset.
module tb_bary_attr_interp;

  logic        clk = 1'b0;
  logic        rst;
  logic        attr_load;
  logic [15:0] attr0, attr1, attr2;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bary_attr_interp_if #(.ATTR_W(16), .Q_W(14)) bus_if ();

  bary_attr_interp #(.ATTR_W(16), .Q_W(14), .FRAC(12)) dut (
    .clk       (clk),
    .rst       (rst),
    .attr_load (attr_load),
    .attr0     (attr0),
    .attr1     (attr1),
    .attr2     (attr2),
    .bus       (bus_if),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the load is taken at the following rising edge.
  task automatic load_attrs(input logic [15:0] a, input logic [15:0] b, input logic [15:0] c);
    attr0 = a; attr1 = b; attr2 = c; attr_load = 1'b1;
    @(negedge clk);
    attr_load = 1'b0;
  endtask

  // One sample into an idle pipe: out_valid must rise exactly 3 cycles after accept.
  task automatic send_lat(input logic [13:0] l1, input logic [13:0] l2,
                          input logic [15:0] exp, input string tag);
    bus_if.lambda1 = l1; bus_if.lambda2 = l2; bus_if.in_valid = 1'b1;
    #1 check({tag, "_in_ready"}, 32'(bus_if.in_ready), 1);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    check({tag, "_lat1"}, 32'(bus_if.out_valid), 0);
    @(negedge clk);
    check({tag, "_lat2"}, 32'(bus_if.out_valid), 0);
    @(negedge clk);
    check({tag, "_lat3"}, 32'(bus_if.out_valid), 1);
    check(tag, 32'(bus_if.attr_out), 32'(exp));
    @(negedge clk);
    check({tag, "_nodup"}, 32'(bus_if.out_valid), 0);
  endtask

  // Wait (bounded) for the next output and consume it with out_ready held high.
  task automatic expect_out(input logic [15:0] exp, input string tag);
    int w = 0;
    while (!bus_if.out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_valid"}, 32'(bus_if.out_valid), 1);
    check(tag, 32'(bus_if.attr_out), 32'(exp));
    @(negedge clk);
  endtask

  initial begin
    int          sent, got, inflight;
    logic        stalled, acc, cons, saw_full;
    logic [15:0] held;

    rst = 1'b1; attr_load = 1'b0; attr0 = '0; attr1 = '0; attr2 = '0;
    bus_if.in_valid = 1'b0; bus_if.lambda1 = '0; bus_if.lambda2 = '0; bus_if.out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("rst_in_ready",  32'(bus_if.in_ready), 0);
    check("rst_out_valid", 32'(bus_if.out_valid), 0);
    check("rst_busy",      32'(busy), 0);
    check("rst_attr_out",  32'(bus_if.attr_out), 0);
    rst = 1'b0;
    @(negedge clk);

    // Exact vertex selection
    load_attrs(16'd100, 16'd200, 16'd300);
    send_lat(14'd0,    14'd0,    16'd100, "sel_a0");
    send_lat(14'd4096, 14'd0,    16'd200, "sel_a1");
    send_lat(14'd0,    14'd4096, 16'd300, "sel_a2");

    // Thirds: sum 12,285,000 rounds to 2999
    load_attrs(16'd0, 16'd3000, 16'd6000);
    send_lat(14'd1365, 14'd1365, 16'd2999, "thirds");

    // Negative clamp (l1 = -0.5) and positive saturation (l1 = -1.0, l0 = 2.0)
    load_attrs(16'd0, 16'd1000, 16'd0);
    send_lat(14'h3800, 14'd0, 16'd0, "neg_clamp");
    load_attrs(16'd40000, 16'd0, 16'd0);
    send_lat(14'h3000, 14'd0, 16'd65535, "pos_sat");

    // Stream of 6 with a downstream stall; result equals l1 when A = 0/4096/0
    load_attrs(16'd0, 16'd4096, 16'd0);
    sent = 0; got = 0; inflight = 0; stalled = 1'b0; held = '0; saw_full = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      bus_if.out_ready = !(cyc >= 2 && cyc <= 7);
      if (stalled) begin
        check("stall_hold_valid", 32'(bus_if.out_valid), 1);
        check("stall_hold_data",  32'(bus_if.attr_out), 32'(held));
      end
      #1;
      check("stream_in_ready", 32'(bus_if.in_ready),
            (inflight == 3 && !bus_if.out_ready) ? 32'd0 : 32'd1);
      if (inflight == 3 && !bus_if.in_ready) saw_full = 1'b1;
      acc = 1'b0;
      if (sent < 6 && bus_if.in_ready) begin
        bus_if.lambda1 = 14'(11 * (sent + 1));
        bus_if.lambda2 = '0;
        bus_if.in_valid = 1'b1;
        sent++;
        acc = 1'b1;
      end else begin
        bus_if.in_valid = 1'b0;
      end
      cons = bus_if.out_valid && bus_if.out_ready;
      if (cons) begin
        check("stream_order", 32'(bus_if.attr_out), 32'(11 * (got + 1)));
        got++;
      end
      stalled  = bus_if.out_valid && !bus_if.out_ready;
      held     = bus_if.attr_out;
      inflight = inflight + int'(acc) - int'(cons);
      @(negedge clk);
    end
    bus_if.in_valid = 1'b0;
    bus_if.out_ready = 1'b1;
    check("stream_count",   32'(got), 6);
    check("stream_full",    32'(saw_full), 1);
    @(negedge clk);
    check("stream_idle",    32'(busy), 0);

    // Attribute load in the same cycle as an accept
    load_attrs(16'd5, 16'd7, 16'd9);
    bus_if.lambda1 = 14'd4096; bus_if.lambda2 = '0; bus_if.in_valid = 1'b1;
    #1 check("ld_p_ready", 32'(bus_if.in_ready), 1);
    @(negedge clk);
    bus_if.lambda1 = '0;
    attr0 = 16'd10; attr1 = 16'd20; attr2 = 16'd30; attr_load = 1'b1;
    #1 check("ld_s_ready", 32'(bus_if.in_ready), 1);
    @(negedge clk);
    attr_load = 1'b0;
    #1 check("ld_t_ready", 32'(bus_if.in_ready), 1);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    expect_out(16'd7,  "ld_inflight");
    expect_out(16'd5,  "ld_same_cycle");
    expect_out(16'd10, "ld_next");

    // Reset with two samples in flight
    bus_if.lambda1 = '0; bus_if.lambda2 = '0; bus_if.in_valid = 1'b1;
    @(negedge clk);
    @(negedge clk);
    bus_if.in_valid = 1'b0;
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    #1 check("rst_mid_in_ready", 32'(bus_if.in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    check("post_rst_valid", 32'(bus_if.out_valid), 0);
    check("post_rst_busy",  32'(busy), 0);
    check("post_rst_attr",  32'(bus_if.attr_out), 0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("post_rst_no_stale", 32'(bus_if.out_valid), 0);
    end
    send_lat(14'd0, 14'd0, 16'd0, "post_rst_cleared_a0");
    load_attrs(16'd100, 16'd200, 16'd300);
    send_lat(14'd0, 14'd4096, 16'd300, "post_rst_a2");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bary_attr_interp.md
Name: bary_attr_interp

Overview:
Downstream consumer of the 1Q12 divider output. Takes the two barycentric weights λ1 and λ2 produced by the divider stages for one pixel and derives λ0 = 1.0 − λ1 − λ2. It then computes the interpolated vertex attribute A = a0·λ0 + a1·λ1 + a2·λ2, with rounding and clamping, and hands it to the shading/depth stage. It is a 3-stage valid/ready pipeline that can be stalled, and it snapshots the per-triangle attributes with each sample.

Parameters:
ATTR_W, 16, width of the unsigned vertex attribute (depth or colour channel)
Q_W, 14, width of the signed 1Q12 weight inputs, matching the divider quotient
FRAC, 12, fractional bits of the weights; 1.0 = 2^FRAC

Ports:
clk  input  1  clock, all logic on the rising edge
rst  input  1  synchronous, active-high reset
attr_load  input  1  load strobe for the per-triangle attribute registers
attr0  input  ATTR_W  vertex 0 attribute, unsigned
attr1  input  ATTR_W  vertex 1 attribute, unsigned
attr2  input  ATTR_W  vertex 2 attribute, unsigned
in_valid  input  1  lambda1/lambda2 valid
in_ready  output  1  block can accept a sample this cycle
lambda1  input  Q_W  signed 1Q12 weight for vertex 1
lambda2  input  Q_W  signed 1Q12 weight for vertex 2
out_valid  output  1  attr_out valid
out_ready  input  1  downstream accepts attr_out
attr_out  output  ATTR_W  interpolated attribute, unsigned, clamped
busy  output  1  any pipeline stage holds a valid sample

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high (fixed). On rst the block clears all stage valids, attr_out, and the attribute registers A0/A1/A2 to 0. It ignores in_valid and attr_load in that cycle. in_ready = 0 during the rst cycle. Reset mid-stream drops all in-flight samples with no output.
- Attribute registers: when attr_load = 1, A0/A1/A2 <= attr0/attr1/attr2 on the clock edge. A sample accepted in the same cycle as attr_load uses the old A values; the new values take effect from the next cycle. attr_load is legal at any time, including while busy.
- Acceptance: a sample is accepted when in_valid && in_ready.
- S1 (on accept):
  - Register λ1 and λ2, sign-extended to Q_W+2 bits.
  - Register λ0 = 2^FRAC − λ1 − λ2, computed in Q_W+2 signed bits with no overflow possible.
  - Snapshot A0/A1/A2 with the sample, so in-flight samples are unaffected by later attr_load.
- S2: register three products p_i = A_i (zero-extended to signed) × λ_i. Each product is (ATTR_W+1)+(Q_W+2) bits.
- S3:
  - sum = p0+p1+p2 in a 36-bit signed accumulator.
  - r = (sum + 2^(FRAC−1)) >>> FRAC, arithmetic shift, i.e. round half up.
  - Clamp r to [0, 2^ATTR_W−1].
  - Register the clamped value as attr_out and set out_valid.
- Latency: 3 cycles from accept to out_valid when there is no stall. Throughput: 1 sample/cycle.
- Flow control, per-stage valid with bubble collapse:
  - S3 advances when !out_valid || out_ready.
  - S_k advances when its successor is empty or advancing.
  - in_ready = !v1 || S1 advancing. in_ready is combinational from out_ready and the valids, with no combinational path from in_valid.
- Output stability: while out_valid && !out_ready, attr_out and out_valid hold stable.
- Capacity and ordering: max 3 samples in flight. Order is preserved and nothing is dropped or duplicated.
- busy = v1 | v2 | v3.
- Boundary cases:
  - Weights outside [0,1] (negative or >1, from rounding or off-triangle pixels) are legal; results outside range saturate via the clamp.
  - λ1 = λ2 = 0 gives exactly A0.
  - λ1 = 4096, λ2 = 0 gives exactly A1.

Test Plan:
- attr = 100/200/300, λ1 = 0, λ2 = 0 -> attr_out = 100 exactly 3 cycles after accept. Then λ1 = 4096, λ2 = 0 -> 200; λ1 = 0, λ2 = 4096 -> 300.
- attr = 0/3000/6000, λ1 = λ2 = 1365 (λ0 = 1366) -> sum 12,285,000 -> attr_out = 2999.
- Clamping:
  - attr = 0/1000/0, λ1 = −2048, λ2 = 0 -> 0 (negative clamp).
  - attr = 40000/0/0, λ1 = −4096, λ2 = 0 (λ0 = 8192) -> 65535 (positive saturate).
- Back-to-back stream of 6 samples with out_ready held low for cycles 2–7:
  - in_ready drops after 3 samples are in flight.
  - attr_out stays stable while stalled.
  - All 6 results emerge in order, with no loss or duplication, once out_ready = 1.
- attr_load to 10/20/30 in the same cycle as accepting sample S (λ1 = λ2 = 0, old attr0 = 5) -> S yields 5. The next sample yields 10, and samples already in flight are unaffected.
- Accept 2 samples, assert rst for 1 cycle on the next edge -> out_valid, busy, and attr_out stay 0, and no stale result appears. A new sample after reset gives a correct result with 3-cycle latency.
